// File: rtl/wb_interconnect_pkg.sv
// Shared types and constants for the two-master / two-slave Wishbone interconnect.
package wb_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_M0  = 2'd1,
    ST_GRANT_M1  = 2'd2,
    ST_FAULT_ACK = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PROG = 2'd1,
    SEL_REG  = 2'd2
  } slaveSel_t;

  // Read word returned to a master whose access was faulted
  localparam logic [15:0] FAULT_WORD = 16'hDEAD;

  localparam int ERR_DECODE_BIT  = 0;
  localparam int ERR_TIMEOUT_BIT = 1;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_M0   = 2'd1;
  localparam logic [1:0] OWNER_M1   = 2'd2;

endpackage

// File: rtl/wb_interconnect_if.sv
// One Wishbone link; the master modport drives the request, the slave modport answers.
interface wb_interconnect_if #(
  parameter int ADDRESS_WIDTH = 24
) ();

  logic [ADDRESS_WIDTH-1:0] adr;
  logic [15:0]              datWr;
  logic [15:0]              datRd;
  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic                     ack;

  modport master (
    output adr, datWr, cyc, stb, we,
    input  datRd, ack
  );

  modport slave (
    input  adr, datWr, cyc, stb, we,
    output datRd, ack
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Maps a Wishbone address onto the program-memory window, the register window or nothing.
module wb_addr_decode
  import wb_interconnect_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 24,
  parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_START = ADDRESS_WIDTH'('h10000),
  parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_END   = ADDRESS_WIDTH'('h1FFFF),
  parameter logic [ADDRESS_WIDTH-1:0] REGMEM_START  = ADDRESS_WIDTH'('h00000),
  parameter logic [ADDRESS_WIDTH-1:0] REGMEM_END    = ADDRESS_WIDTH'('h0FFFF)
) (
  input  logic [ADDRESS_WIDTH-1:0] adr,
  output slaveSel_t                sel
);

  localparam logic [ADDRESS_WIDTH-1:0] PROG_SPAN = PROGMEM_END - PROGMEM_START;
  localparam logic [ADDRESS_WIDTH-1:0] REG_SPAN  = REGMEM_END - REGMEM_START;

  logic [ADDRESS_WIDTH-1:0] progOfs;
  logic [ADDRESS_WIDTH-1:0] regOfs;

  // Offset-from-base compare: an address below the base wraps to a huge offset
  always_comb begin
    progOfs = adr - PROGMEM_START;
    regOfs  = adr - REGMEM_START;
    sel     = SEL_NONE;
    if (progOfs <= PROG_SPAN) begin
      sel = SEL_PROG;
    end else if (regOfs <= REG_SPAN) begin
      sel = SEL_REG;
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Two-master, two-slave Wishbone interconnect: alternating-priority arbiter, address
// decode, zero-latency response routing, and decode / ack-timeout fault responses.
module wb_interconnect
  import wb_interconnect_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 24,
  parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_START = ADDRESS_WIDTH'('h10000),
  parameter logic [ADDRESS_WIDTH-1:0] PROGMEM_END   = ADDRESS_WIDTH'('h1FFFF),
  parameter logic [ADDRESS_WIDTH-1:0] REGMEM_START  = ADDRESS_WIDTH'('h00000),
  parameter logic [ADDRESS_WIDTH-1:0] REGMEM_END    = ADDRESS_WIDTH'('h0FFFF),
  parameter int                       ACK_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_interconnect_if.slave  m0,
  wb_interconnect_if.slave  m1,
  wb_interconnect_if.master sProg,
  wb_interconnect_if.master sReg,
  input  logic              clrErr,
  output logic [1:0]        errStatus,
  output logic [1:0]        grantOwner
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

  arbState_t state;
  logic      ownerM1;
  logic      lastM1;
  logic [15:0] waitCnt;

  logic [ADDRESS_WIDTH-1:0] ownAdr;
  logic [15:0] ownDat;
  logic        ownCyc;
  logic        ownStb;
  logic        ownWe;
  slaveSel_t   sel;

  logic        granted;
  logic        inFault;
  logic        selProg;
  logic        selReg;
  logic        slvAck;
  logic [15:0] slvDat;
  logic        pending;
  logic        decodeHit;
  logic        timeoutHit;
  logic        rspAck;
  logic [15:0] rspDat;
  logic [1:0]  newErr;

  // ownerM1 stays valid through FAULT_ACK so the fault word reaches the right master
  always_comb begin
    ownAdr = ownerM1 ? m1.adr   : m0.adr;
    ownDat = ownerM1 ? m1.datWr : m0.datWr;
    ownCyc = ownerM1 ? m1.cyc   : m0.cyc;
    ownStb = ownerM1 ? m1.stb   : m0.stb;
    ownWe  = ownerM1 ? m1.we    : m0.we;
  end

  wb_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .PROGMEM_START (PROGMEM_START),
    .PROGMEM_END   (PROGMEM_END),
    .REGMEM_START  (REGMEM_START),
    .REGMEM_END    (REGMEM_END)
  ) uDecode (
    .adr (ownAdr),
    .sel (sel)
  );

  always_comb begin
    granted    = (state == ST_GRANT_M0) || (state == ST_GRANT_M1);
    inFault    = (state == ST_FAULT_ACK);
    selProg    = granted && ownCyc && (sel == SEL_PROG);
    selReg     = granted && ownCyc && (sel == SEL_REG);
    slvAck     = (selProg && sProg.ack) || (selReg && sReg.ack);
    slvDat     = selProg ? sProg.datRd : (selReg ? sReg.datRd : 16'h0000);
    pending    = granted && ownCyc && ownStb && (sel != SEL_NONE) && !slvAck;
    decodeHit  = granted && ownCyc && ownStb && (sel == SEL_NONE);
    // A slave ack in the deadline cycle clears pending, so it beats the timeout
    timeoutHit = pending && (waitCnt == TIMEOUT_CNT);
    rspAck     = inFault || slvAck;
    rspDat     = inFault ? FAULT_WORD : slvDat;
    newErr                  = 2'b00;
    newErr[ERR_DECODE_BIT]  = decodeHit;
    newErr[ERR_TIMEOUT_BIT] = timeoutHit;
  end

  assign sProg.cyc   = selProg;
  assign sProg.stb   = selProg && ownStb;
  assign sProg.we    = selProg && ownWe;
  assign sProg.adr   = selProg ? ownAdr : '0;
  assign sProg.datWr = selProg ? ownDat : 16'h0000;

  assign sReg.cyc    = selReg;
  assign sReg.stb    = selReg && ownStb;
  assign sReg.we     = selReg && ownWe;
  assign sReg.adr    = selReg ? ownAdr : '0;
  assign sReg.datWr  = selReg ? ownDat : 16'h0000;

  // rspAck/rspDat are already zero outside GRANT/FAULT, so only the owner gate is needed
  assign m0.ack   = !ownerM1 && rspAck;
  assign m0.datRd = ownerM1 ? 16'h0000 : rspDat;
  assign m1.ack   = ownerM1 && rspAck;
  assign m1.datRd = ownerM1 ? rspDat : 16'h0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ownerM1    <= 1'b0;
      lastM1     <= 1'b1;
      waitCnt    <= 16'h0000;
      errStatus  <= 2'b00;
      grantOwner <= OWNER_NONE;
    end else begin
      errStatus <= (clrErr ? 2'b00 : errStatus) | newErr;
      waitCnt   <= (pending && !timeoutHit) ? waitCnt + 16'd1 : 16'h0000;
      case (state)
        ST_IDLE: begin
          if (m0.cyc && (!m1.cyc || lastM1)) begin
            state      <= ST_GRANT_M0;
            ownerM1    <= 1'b0;
            lastM1     <= 1'b0;
            grantOwner <= OWNER_M0;
          end else if (m1.cyc) begin
            state      <= ST_GRANT_M1;
            ownerM1    <= 1'b1;
            lastM1     <= 1'b1;
            grantOwner <= OWNER_M1;
          end
        end
        ST_GRANT_M0, ST_GRANT_M1: begin
          if (!ownCyc) begin
            state      <= ST_IDLE;
            grantOwner <= OWNER_NONE;
          end else if (decodeHit || timeoutHit) begin
            state <= ST_FAULT_ACK;
          end
        end
        ST_FAULT_ACK: begin
          state <= ownerM1 ? ST_GRANT_M1 : ST_GRANT_M0;
        end
        default: begin
          state      <= ST_IDLE;
          grantOwner <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule
